// File: rtl/ray_pkg.sv
// Shared definitions for the ray pipeline front end.
// Default raster size and the scan-generator state encoding.
package ray_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int COORD_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major x/y raster counter with advance and synchronous clear.
// The last pixel wraps back to (0,0) on advance.
module raster_counter
    import ray_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_last_x,
    output logic               o_last_frame
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_last_x;
    logic               w_last_y;

    assign w_last_x = (r_x == X_MAX);
    assign w_last_y = (r_y == Y_MAX);

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_last_x     = w_last_x;
    assign o_last_frame = w_last_x && w_last_y;

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster scan generator feeding Ray_Core over valid/ready.
// Define PIXEL_SCAN_GEN_CONTINUOUS_EN to rescan frames back to back.
module pixel_scan_gen
    import ray_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               ready,
    output logic               valid,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               last_in_line,
    output logic               last_in_frame,
    output logic               busy,
    output logic               frame_done
);

    state_t r_state;
    state_t w_next;
    logic   w_xfer;
    logic   w_clear;
    logic   w_last_x;
    logic   w_last_frame;
    logic   w_frame_end;

    assign w_xfer      = valid && ready;
    assign w_clear     = (r_state != RUN) || abort;
    assign w_frame_end = w_xfer && w_last_frame && !abort;

    raster_counter #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_advance    (w_xfer),
        .o_x          (pixel_x),
        .o_y          (pixel_y),
        .o_last_x     (w_last_x),
        .o_last_frame (w_last_frame)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

`ifdef PIXEL_SCAN_GEN_CONTINUOUS_EN
    // Frame boundary pulse while staying in RUN.
    logic r_wrap;

    always_ff @(posedge clk) begin
        if (!rst) r_wrap <= 1'b0;
        else      r_wrap <= w_frame_end && (r_state == RUN);
    end
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start && !abort) w_next = RUN;
            RUN: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_frame_end) begin
`ifdef PIXEL_SCAN_GEN_CONTINUOUS_EN
                    w_next = RUN;
`else
                    w_next = DONE;
`endif
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        valid         = (r_state == RUN);
        busy          = (r_state == RUN);
        last_in_line  = valid && w_last_x;
        last_in_frame = valid && w_last_frame;
`ifdef PIXEL_SCAN_GEN_CONTINUOUS_EN
        frame_done    = r_wrap;
`else
        frame_done    = (r_state == DONE);
`endif
    end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Self-checking bench for pixel_scan_gen on a 4x3 raster.
// Expected pixels are queued at stimulus time and popped on transfer.
module tb_pixel_scan_gen;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int CW = 10;
`ifdef PIXEL_SCAN_GEN_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          lil;
        logic          lif;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          ready;
    logic          valid;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          last_in_line;
    logic          last_in_frame;
    logic          busy;
    logic          frame_done;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pixel_scan_gen #(.H_RES(H), .V_RES(V), .COORD_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .ready         (ready),
        .valid         (valid),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .last_in_line  (last_in_line),
        .last_in_frame (last_in_frame),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic push_frame();
        exp_t e;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                e.x   = CW'(x);
                e.y   = CW'(y);
                e.lil = (x == H - 1);
                e.lif = (x == H - 1) && (y == V - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid, busy, frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000", {valid, busy, frame_done});
        end
        checks++;
        if ({pixel_x, pixel_y} !== '0) begin
            errors++;
            $display("FAIL reset_xy got (%0d,%0d) want (0,0)", pixel_x, pixel_y);
        end
        checks++;
        if ({last_in_line, last_in_frame} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got %b want 00", {last_in_line, last_in_frame});
        end
    endtask

    task automatic test_frame();
        exp_t e;
        bit   exp_v;
        bit   exp_fd;
        int   n_end;
        int   fd_cnt = 0;
        n_end = CONT ? 26 : 14;
        q.delete();
        repeat (3) push_frame();
        rst = 1'b1; ready = 1'b1; start = 1'b1;
        for (int n = 1; n <= n_end; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            exp_v  = CONT ? 1'b1 : (n <= 12);
            exp_fd = (n == 13) || (CONT && n == 25);
            checks++;
            if (valid !== exp_v || busy !== exp_v) begin
                errors++;
                $display("FAIL frame_valid c%0d got v%b b%b want %b", n, valid, busy, exp_v);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL frame_done c%0d got %b want %b", n, frame_done, exp_fd);
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_queue c%0d got extra pixel want none", n);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (pixel_x !== e.x || pixel_y !== e.y ||
                        last_in_line !== e.lil || last_in_frame !== e.lif) begin
                        errors++;
                        $display("FAIL frame_pix c%0d got (%0d,%0d,%b,%b) want (%0d,%0d,%b,%b)",
                                 n, pixel_x, pixel_y, last_in_line, last_in_frame,
                                 e.x, e.y, e.lil, e.lif);
                    end
                end
            end else begin
                checks++;
                if ({pixel_x, pixel_y, last_in_line, last_in_frame} !== '0) begin
                    errors++;
                    $display("FAIL frame_idle_xy c%0d got (%0d,%0d) want (0,0)", n, pixel_x, pixel_y);
                end
            end
        end
        checks++;
        if (fd_cnt != (CONT ? 2 : 1)) begin
            errors++;
            $display("FAIL frame_done_count got %0d want %0d", fd_cnt, CONT ? 2 : 1);
        end
        checks++;
        if (q.size() != (CONT ? 10 : 24)) begin
            errors++;
            $display("FAIL frame_xfers got %0d left want %0d", q.size(), CONT ? 10 : 24);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_stop got valid %b want 0", valid);
        end
        q.delete();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   stalls = 0;
        int   xfers  = 0;
        int   cyc    = 0;
        q.delete();
        push_frame();
        ready = 1'b1; start = 1'b1;
        while (xfers < 12 && cyc < 40) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            e = q[0];
            checks++;
            if (valid !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL bp_valid c%0d got v%b fd%b want v1 fd0", cyc, valid, frame_done);
            end
            checks++;
            if (pixel_x !== e.x || pixel_y !== e.y ||
                last_in_line !== e.lil || last_in_frame !== e.lif) begin
                errors++;
                $display("FAIL bp_pix c%0d got (%0d,%0d,%b,%b) want (%0d,%0d,%b,%b)",
                         cyc, pixel_x, pixel_y, last_in_line, last_in_frame,
                         e.x, e.y, e.lil, e.lif);
            end
            if (e.x == 2 && e.y == 1 && stalls < 3) begin
                ready = 1'b0;
                stalls++;
            end else begin
                ready = 1'b1;
                void'(q.pop_front());
                xfers++;
            end
        end
        checks++;
        if (xfers != 12 || cyc != 15) begin
            errors++;
            $display("FAIL bp_count got %0d xfers in %0d cyc want 12 in 15", xfers, cyc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b1 || valid !== CONT) begin
            errors++;
            $display("FAIL bp_done got fd%b v%b want fd1 v%b", frame_done, valid, CONT);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        q.delete();
    endtask

    task automatic test_start_abort();
        exp_t e;
        bit   hit = 1'b0;
        q.delete();
        push_frame();
        ready = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if (valid !== 1'b1 || pixel_x !== e.x || pixel_y !== e.y) begin
                errors++;
                $display("FAIL sa_pix c%0d got v%b (%0d,%0d) want v1 (%0d,%0d)",
                         cyc, valid, pixel_x, pixel_y, e.x, e.y);
            end
            start = (e.x == 1 && e.y == 1);
            if (e.x == 1 && e.y == 2) begin
                abort = 1'b1;
                hit   = 1'b1;
            end
        end
        if (!hit) begin
            errors++;
            $display("FAIL sa_timeout got no (1,2) want (1,2)");
        end
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            abort = 1'b0;
            checks++;
            if ({valid, busy, frame_done} !== 3'b000 || {pixel_x, pixel_y} !== '0) begin
                errors++;
                $display("FAIL sa_abort c%0d got v%b b%b fd%b (%0d,%0d) want idle",
                         n, valid, busy, frame_done, pixel_x, pixel_y);
            end
        end
        abort = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0; start = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sa_both got v%b b%b want 00", valid, busy);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || {pixel_x, pixel_y} !== '0) begin
            errors++;
            $display("FAIL sa_restart got v%b (%0d,%0d) want v1 (0,0)", valid, pixel_x, pixel_y);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        q.delete();
    endtask

    task automatic test_reset_midframe();
        bit hit = 1'b0;
        ready = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (valid === 1'b1 && pixel_x == 2 && pixel_y == 1) begin
                rst = 1'b0;
                hit = 1'b1;
            end
        end
        if (!hit) begin
            errors++;
            $display("FAIL rm_timeout got no (2,1) want (2,1)");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++;
        if ({valid, busy, frame_done} !== 3'b000 || {pixel_x, pixel_y} !== '0) begin
            errors++;
            $display("FAIL rm_state got v%b b%b fd%b (%0d,%0d) want idle",
                     valid, busy, frame_done, pixel_x, pixel_y);
        end
        for (int n = 0; n < 14; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (frame_done !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL rm_quiet c%0d got fd%b v%b want 00", n, frame_done, valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_start_abort();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_scan_gen.md
Name: pixel_scan_gen

Overview:
- Upstream feeder for Ray_Core: walks the frame raster and emits one (pixel_x, pixel_y) per accepted transfer on a valid/ready handshake.
- Row-major order: x fastest, then y.
- Started by a one-cycle start request; signals frame completion with a one-cycle pulse.
- Back-pressure via ready lets it sit in front of a stalling ray pipeline. Tie ready high for a core that always accepts.

Parameters:
- H_RES, 640, pixels per line; 2 ≤ H_RES ≤ 2^COORD_W.
- V_RES, 480, lines per frame; 2 ≤ V_RES ≤ 2^COORD_W.
- COORD_W, 10, coordinate width; matches Ray_Core pixel_x/pixel_y.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  stop the scan; return to IDLE.
- ready  in  1  downstream can accept this cycle.
- valid  out  1  pixel_x/pixel_y hold a pixel to transfer (drives Ray_Core valid).
- pixel_x  out  COORD_W  column, 0..H_RES-1.
- pixel_y  out  COORD_W  row, 0..V_RES-1.
- last_in_line  out  1  current pixel has x == H_RES-1.
- last_in_frame  out  1  current pixel is (H_RES-1, V_RES-1).
- busy  out  1  scan in progress (RUN state).
- frame_done  out  1  one-cycle pulse after the final pixel transfers.

Behaviour:
- Reset (rst low at a clock edge):
  - State to IDLE.
  - valid, busy, frame_done, last_in_line, last_in_frame = 0.
  - pixel_x = pixel_y = 0.
  - Reset wins over every other input, including mid-frame.
- Transfer: a transfer occurs when valid && ready at a rising edge.
- States:
  - IDLE: valid = 0, busy = 0. If start is sampled high (and abort low), next cycle: RUN, valid = 1, x = y = 0.
  - Start latency is 1 cycle.
  - RUN: valid = 1, busy = 1.
  - RUN, stall (no transfer): pixel_x, pixel_y and flags hold stable; valid stays high.
  - RUN, transfer with x < H_RES-1: x+1.
  - RUN, transfer with x == H_RES-1 and not last: x = 0, y+1.
  - RUN, transfer on last pixel: next cycle is DONE. valid = 0, x = y = 0.
  - DONE: frame_done = 1 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while in RUN or DONE: ignored; no queuing.
- Abort:
  - abort high in RUN: next cycle IDLE, valid = 0, x = y = 0, no frame_done.
  - A transfer in the abort cycle still counts downstream.
  - abort and start together in IDLE: abort wins; stay IDLE.
- Flags: last_in_line and last_in_frame are combinational from the registered coordinates, gated by valid.
- Arithmetic: unsigned compares against H_RES-1 and V_RES-1. Counters never exceed range, so no wrap beyond the frame.
- Ray_Core has no ready: with ready tied high, exactly one pixel per cycle, H_RES*V_RES consecutive valid cycles.

Optional Feature:
- Macro: PIXEL_SCAN_GEN_CONTINUOUS_EN.
- Defined:
  - On the last-pixel transfer, the next cycle is RUN with x = y = 0 and valid = 1. There is no valid bubble.
  - frame_done pulses in that same cycle.
  - DONE state is unused.
  - Only abort or reset stops the scan.
- Undefined: single-frame behaviour as above.

Decomposition:
- Shared package ray_pkg holds:
  - Localparams for default H_RES/V_RES/COORD_W, shared with Ray_Core.
  - State encoding typedef: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- Sub-module raster_counter: x/y counters with advance input, last_in_line and last_in_frame outputs, synchronous clear. The FSM stays in pixel_scan_gen.

Test Plan:
- Reset mid-frame at (5,3): rst low for 1 cycle → next cycle valid = 0, x = y = 0, state IDLE, frame_done never pulses.
- H_RES = 4, V_RES = 3, ready = 1, start pulse at cycle 0:
  - valid from cycle 1 to cycle 12; sequence (0,0),(1,0),(2,0),(3,0),(0,1) … (3,2).
  - last_in_line on x = 3; last_in_frame only at (3,2).
  - frame_done at cycle 13; valid = 0 at cycle 13.
- Back-pressure: ready low for 3 cycles at (2,1) → pixel_x = 2, pixel_y = 1, valid = 1 held for all 3 cycles. Resumes with (3,1) one cycle after ready returns. Total transfers still 12.
- start asserted during RUN at (1,1) → no restart, sequence unchanged. abort at (1,2) → next cycle valid = 0, busy = 0, no frame_done.
- CONTINUOUS_EN, 4x3, ready = 1: valid never drops. (0,0) follows (3,2) on the next cycle. frame_done pulses at cycles 13 and 25.
- Default 640x480, ready = 1 → exactly 307200 transfers; final pixel (639,479) with last_in_frame = 1.
